// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive header parser.
package eth_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned ETH_HDR_BYTES = 14;
  localparam int unsigned HDR_CNT_W     = 4;
  localparam int unsigned MAC_W         = 48;
  localparam int unsigned ETYPE_W       = 16;
  localparam int unsigned STAT_W        = 32;

  localparam logic [ETYPE_W-1:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [MAC_W-1:0]   MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [MAC_W-1:0]   dst;
    logic [MAC_W-1:0]   src;
    logic [ETYPE_W-1:0] ethertype;
  } eth_hdr_t;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } rx_state_t;

  // Saturating increment for statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/eth_rx_hdr_parser_if.sv
// Byte-wide AXI-Stream input and output of the receive header parser.
interface eth_rx_hdr_parser_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  // Frame source / datagram sink side.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  // Parser side.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer (data plus tlast) with a registered ready.
module axis_skid_buf #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  output logic                  o_m_valid,
  input  logic                  i_m_ready
);

  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  logic [ENT_W-1:0] r_out;
  logic [ENT_W-1:0] r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;
  logic             w_push;
  logic             w_load;

  assign w_push = i_s_valid & ~r_skid_valid;
  assign w_load = ~r_out_valid | i_m_ready;

  // Output register refills from the skid entry first to preserve order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_push;
        if (w_push) begin
          r_out <= {i_s_last, i_s_data};
        end
      end
    end else if (w_push) begin
      r_skid       <= {i_s_last, i_s_data};
      r_skid_valid <= 1'b1;
    end
  end

  assign o_s_ready              = ~r_skid_valid;
  assign o_m_valid              = r_out_valid;
  assign {o_m_last, o_m_data}   = r_out;

endmodule

// File: rtl/eth_rx_hdr_parser.sv
// Ethernet receive header parser: filters on dst MAC / EtherType, strips the header.
// Optional statistics counters are enabled with ETH_RX_STATS_EN.
module eth_rx_hdr_parser
  import eth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter bit          PROMISC      = 1'b0,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MAC_W-1:0]      local_mac,
  eth_rx_hdr_parser_if.slave    bus,
  output logic                  hdr_valid,
  output logic [MAC_W-1:0]      hdr_dst_mac,
  output logic [MAC_W-1:0]      hdr_src_mac,
  output logic [ETYPE_W-1:0]    hdr_ethertype
`ifdef ETH_RX_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_rx_ok,
  output logic [STAT_W-1:0]     stat_rx_drop_filter,
  output logic [STAT_W-1:0]     stat_rx_runt
`endif
);

  localparam int unsigned SR_W = (ETH_HDR_BYTES - 1) * BYTE_W;
  localparam logic [HDR_CNT_W-1:0] CNT_LAST       = HDR_CNT_W'(ETH_HDR_BYTES - 1);
  localparam logic [HDR_CNT_W-1:0] CNT_MAC_SAMPLE = HDR_CNT_W'(5);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_rx_hdr_parser: DATA_WIDTH must be 8");
  end

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [HDR_CNT_W-1:0] r_cnt;
  logic [HDR_CNT_W-1:0] w_cnt_nxt;
  logic [SR_W-1:0]      r_sr;
  logic [MAC_W-1:0]     r_local_mac;
  eth_hdr_t             r_hdr;
  logic                 r_hdr_valid;

  eth_hdr_t             w_hdr;
  logic                 w_pass;
  logic                 w_s_ready;
  logic                 w_push;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_runt;
  logic                 w_sr_en;
  logic                 w_mac_en;
  logic                 w_skid_ready;

  // Full header as seen on the byte-13 beat: 13 stored bytes plus the current one.
  assign w_hdr  = eth_hdr_t'({r_sr, bus.s_axis_tdata});
  assign w_pass = (PROMISC || (w_hdr.dst == r_local_mac) ||
                   (ACCEPT_BCAST && (w_hdr.dst == MAC_BCAST))) &&
                  (w_hdr.ethertype == ETHERTYPE_IPV4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HDR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_ready   = 1'b1;
    w_push      = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_runt      = 1'b0;
    w_sr_en     = 1'b0;
    w_mac_en    = 1'b0;
    unique case (r_state)
      HDR: begin
        if (bus.s_axis_tvalid) begin
          w_sr_en  = 1'b1;
          w_mac_en = (r_cnt == CNT_MAC_SAMPLE);
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            if (bus.s_axis_tlast) begin
              w_runt = 1'b1;
            end else if (w_pass) begin
              w_accept    = 1'b1;
              w_state_nxt = FWD;
            end else begin
              w_reject    = 1'b1;
              w_state_nxt = DROP;
            end
          end else if (bus.s_axis_tlast) begin
            w_runt    = 1'b1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + HDR_CNT_W'(1);
          end
        end
      end
      FWD: begin
        w_s_ready = w_skid_ready;
        if (bus.s_axis_tvalid && w_skid_ready) begin
          w_push = 1'b1;
          if (bus.s_axis_tlast) begin
            w_state_nxt = HDR;
          end
        end
      end
      DROP: begin
        if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
          w_state_nxt = HDR;
        end
      end
      default: begin
        w_state_nxt = HDR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Header capture; published fields only change on an accepted header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr        <= '0;
      r_local_mac <= '0;
      r_hdr       <= '0;
      r_hdr_valid <= 1'b0;
    end else begin
      if (w_sr_en) begin
        r_sr <= {r_sr[SR_W-BYTE_W-1:0], bus.s_axis_tdata};
      end
      if (w_mac_en) begin
        r_local_mac <= local_mac;
      end
      if (w_accept) begin
        r_hdr <= w_hdr;
      end
      r_hdr_valid <= w_accept;
    end
  end

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_s_data  (bus.s_axis_tdata),
    .i_s_last  (bus.s_axis_tlast),
    .i_s_valid (w_push),
    .o_s_ready (w_skid_ready),
    .o_m_data  (bus.m_axis_tdata),
    .o_m_last  (bus.m_axis_tlast),
    .o_m_valid (bus.m_axis_tvalid),
    .i_m_ready (bus.m_axis_tready)
  );

  assign bus.s_axis_tready = w_s_ready;
  assign hdr_valid         = r_hdr_valid;
  assign hdr_dst_mac       = r_hdr.dst;
  assign hdr_src_mac       = r_hdr.src;
  assign hdr_ethertype     = r_hdr.ethertype;

`ifdef ETH_RX_STATS_EN
  logic [STAT_W-1:0] r_stat_ok;
  logic [STAT_W-1:0] r_stat_drop;
  logic [STAT_W-1:0] r_stat_runt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_ok   <= '0;
      r_stat_drop <= '0;
      r_stat_runt <= '0;
    end else begin
      if (r_hdr_valid) begin
        r_stat_ok <= sat_inc(r_stat_ok);
      end
      if (w_reject) begin
        r_stat_drop <= sat_inc(r_stat_drop);
      end
      if (w_runt) begin
        r_stat_runt <= sat_inc(r_stat_runt);
      end
    end
  end

  assign stat_rx_ok          = r_stat_ok;
  assign stat_rx_drop_filter = r_stat_drop;
  assign stat_rx_runt        = r_stat_runt;
`endif

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// Directed self-checking bench for eth_rx_hdr_parser (stats checked when ETH_RX_STATS_EN is set).
module tb_eth_rx_hdr_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] local_mac;
  logic        hdr_valid;
  logic [47:0] hdr_dst_mac;
  logic [47:0] hdr_src_mac;
  logic [15:0] hdr_ethertype;
`ifdef ETH_RX_STATS_EN
  logic [31:0] stat_rx_ok;
  logic [31:0] stat_rx_drop_filter;
  logic [31:0] stat_rx_runt;
`endif

  eth_rx_hdr_parser_if #(.DATA_WIDTH(8)) bus();

  eth_rx_hdr_parser #(
    .DATA_WIDTH   (8),
    .PROMISC      (1'b0),
    .ACCEPT_BCAST (1'b1)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .local_mac     (local_mac),
    .bus           (bus),
    .hdr_valid     (hdr_valid),
    .hdr_dst_mac   (hdr_dst_mac),
    .hdr_src_mac   (hdr_src_mac),
    .hdr_ethertype (hdr_ethertype)
`ifdef ETH_RX_STATS_EN
    ,
    .stat_rx_ok          (stat_rx_ok),
    .stat_rx_drop_filter (stat_rx_drop_filter),
    .stat_rx_runt        (stat_rx_runt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;
  int          hv_cnt = 0;
  int          hv_long = 0;
  int          ready_waits = 0;
  int          exp_ok = 0;
  int          exp_drop = 0;
  int          exp_runt = 0;
  logic [8:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [8:0]  exp_q[$];

  // Sink: drives m_axis_tready, records beats, checks hold-while-stalled and hdr_valid width.
  initial begin
    logic       prev_stall;
    logic [8:0] held;
    logic       hv_prev;
    prev_stall = 1'b0;
    held       = '0;
    hv_prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall         = 1'b0;
        hv_prev            = 1'b0;
        bus.m_axis_tready  = 1'b1;
      end else begin
        if (prev_stall) begin
          n_cmp++;
          if (bus.m_axis_tvalid !== 1'b1 || {bus.m_axis_tlast, bus.m_axis_tdata} !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b %h, want v=1 %h", bus.m_axis_tvalid,
                     {bus.m_axis_tlast, bus.m_axis_tdata}, held);
          end
        end
        case (rdy_mode)
          0:       bus.m_axis_tready = 1'b1;
          1:       bus.m_axis_tready = ($urandom_range(0, 99) < 30);
          default: bus.m_axis_tready = 1'b0;
        endcase
        if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready) begin
          rx_q.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
        end
        prev_stall = (bus.m_axis_tvalid === 1'b1) && !bus.m_axis_tready;
        held       = {bus.m_axis_tlast, bus.m_axis_tdata};
        if (hdr_valid === 1'b1) begin
          hv_cnt++;
          if (hv_prev) hv_long++;
        end
        hv_prev = (hdr_valid === 1'b1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int k;
    k = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = l;
    while (bus.s_axis_tready !== 1'b1 && k < 1000) begin
      ready_waits++;
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: tready=%b, want 1 within 1000 cycles", bus.s_axis_tready);
    end
    @(negedge clk);
  endtask

  task automatic push_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    for (int i = 5; i >= 0; i--) tx_q.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) tx_q.push_back(s[i*8 +: 8]);
    tx_q.push_back(t[15:8]);
    tx_q.push_back(t[7:0]);
  endtask

  task automatic send_q();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], i == tx_q.size() - 1);
    tx_q.delete();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    local_mac         = LOCAL_MAC;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_cmp++; if (hdr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hdr_valid: got %b want 0", hdr_valid); end
    n_cmp++; if (hdr_dst_mac !== 48'h0) begin n_fail++; $display("FAIL rst_dst: got %h want 0", hdr_dst_mac); end
    n_cmp++; if (hdr_src_mac !== 48'h0) begin n_fail++; $display("FAIL rst_src: got %h want 0", hdr_src_mac); end
    n_cmp++; if (hdr_ethertype !== 16'h0) begin n_fail++; $display("FAIL rst_etype: got %h want 0", hdr_ethertype); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unicast();
    rx_q.delete(); hv_cnt = 0;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    tx_q.push_back(8'h45);
    for (int i = 0; i < 15; i++) begin
      send_byte(tx_q[i], 1'b0);
      if (i == 13) begin
        n_cmp++; if (hdr_valid !== 1'b1) begin n_fail++; $display("FAIL uc_hv_timing: got %b want 1", hdr_valid); end
      end
    end
    n_cmp++;
    if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'h45) begin
      n_fail++; $display("FAIL uc_latency: got v=%b d=%h want v=1 d=45", bus.m_axis_tvalid, bus.m_axis_tdata);
    end
    tx_q.delete();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h14, 1'b1);
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    wait_rx(4);
    exp_ok++;
    exp_q = '{9'h045, 9'h000, 9'h000, 9'h114};
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL uc_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL uc_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (hv_cnt !== 1) begin n_fail++; $display("FAIL uc_hv_cnt: got %0d want 1", hv_cnt); end
    n_cmp++; if (hdr_src_mac !== SRC_MAC) begin n_fail++; $display("FAIL uc_src: got %h want %h", hdr_src_mac, SRC_MAC); end
    n_cmp++; if (hdr_dst_mac !== LOCAL_MAC) begin n_fail++; $display("FAIL uc_dst: got %h want %h", hdr_dst_mac, LOCAL_MAC); end
    n_cmp++; if (hdr_ethertype !== 16'h0800) begin n_fail++; $display("FAIL uc_etype: got %h want 0800", hdr_ethertype); end
  endtask

  task automatic test_mac_reject();
    rx_q.delete(); hv_cnt = 0; ready_waits = 0;
    push_hdr(48'h02_00_00_00_00_09, 48'h0A_0B_0C_0D_0E_0F, 16'h0800);
    tx_q.push_back(8'h45); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h14);
    send_q();
    repeat (6) @(negedge clk);
    exp_drop++;
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL rej_beats: got %0d want 0", rx_q.size()); end
    n_cmp++; if (hv_cnt !== 0) begin n_fail++; $display("FAIL rej_hv: got %0d want 0", hv_cnt); end
    n_cmp++; if (ready_waits !== 0) begin n_fail++; $display("FAIL rej_tready: got %0d low cycles want 0", ready_waits); end
    n_cmp++; if (hdr_src_mac !== SRC_MAC) begin n_fail++; $display("FAIL rej_src_hold: got %h want %h", hdr_src_mac, SRC_MAC); end
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    send_q();
    wait_rx(3);
    exp_ok++;
    exp_q = '{9'h011, 9'h022, 9'h133};
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rej_next_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rej_next_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bcast_type();
    rx_q.delete(); hv_cnt = 0;
    push_hdr(48'hFF_FF_FF_FF_FF_FF, SRC_MAC, 16'h0800);
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
    send_q();
    wait_rx(2);
    exp_ok++;
    exp_q = '{9'h0AA, 9'h1BB};
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bc_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bc_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (hdr_dst_mac !== 48'hFF_FF_FF_FF_FF_FF) begin n_fail++; $display("FAIL bc_dst: got %h want ffffffffffff", hdr_dst_mac); end
    rx_q.delete(); hv_cnt = 0;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h86DD);
    tx_q.push_back(8'h60); tx_q.push_back(8'h00);
    send_q();
    repeat (6) @(negedge clk);
    exp_drop++;
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL v6_beats: got %0d want 0", rx_q.size()); end
    n_cmp++; if (hv_cnt !== 0) begin n_fail++; $display("FAIL v6_hv: got %0d want 0", hv_cnt); end
`ifdef ETH_RX_STATS_EN
    n_cmp++; if (stat_rx_ok !== 32'(exp_ok)) begin n_fail++; $display("FAIL stat_ok: got %0d want %0d", stat_rx_ok, exp_ok); end
    n_cmp++; if (stat_rx_drop_filter !== 32'(exp_drop)) begin n_fail++; $display("FAIL stat_drop: got %0d want %0d", stat_rx_drop_filter, exp_drop); end
`endif
  endtask

  task automatic test_runts();
    rx_q.delete(); hv_cnt = 0;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    while (tx_q.size() > 10) void'(tx_q.pop_back());
    send_q();
    exp_runt++;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    send_q();
    exp_runt++;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    tx_q.push_back(8'h5A); tx_q.push_back(8'hA5);
    send_q();
    wait_rx(2);
    exp_ok++;
    exp_q = '{9'h05A, 9'h1A5};
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL runt_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL runt_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (hv_cnt !== 1) begin n_fail++; $display("FAIL runt_hv: got %0d want 1", hv_cnt); end
`ifdef ETH_RX_STATS_EN
    n_cmp++; if (stat_rx_runt !== 32'(exp_runt)) begin n_fail++; $display("FAIL stat_runt: got %0d want %0d", stat_rx_runt, exp_runt); end
`endif
  endtask

  task automatic test_backpressure();
    rx_q.delete();
    rdy_mode = 1;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
    send_q();
    wait_rx(64);
    rdy_mode = 0;
    exp_ok++;
    n_cmp++; if (rx_q.size() !== 64) begin n_fail++; $display("FAIL bp_len: got %0d want 64", rx_q.size()); end
    else for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (rx_q[i] !== {(i == 63), 8'(i)}) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, rx_q[i], {(i == 63), 8'(i)});
      end
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete(); hv_cnt = 0;
    rdy_mode = 1;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    for (int i = 0; i < 8; i++) tx_q.push_back(8'hC0 + 8'(i));
    send_q();
    push_hdr(48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_00_07, 16'h0800);
    for (int i = 0; i < 4; i++) tx_q.push_back(8'hD0 + 8'(i));
    send_q();
    wait_rx(12);
    rdy_mode = 0;
    exp_ok += 2;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'hC0 + 8'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 8'hD0 + 8'(i)});
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (hv_cnt !== 2) begin n_fail++; $display("FAIL b2b_hv: got %0d want 2", hv_cnt); end
    n_cmp++; if (hdr_src_mac !== 48'h02_00_00_00_00_07) begin n_fail++; $display("FAIL b2b_src: got %h want 020000000007", hdr_src_mac); end
  endtask

  task automatic test_reset_mid();
    rx_q.delete();
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    for (int i = 0; i < 5; i++) tx_q.push_back(8'h60 + 8'(i));
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b0);
    tx_q.delete();
    n_cmp++; if (bus.m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tvalid: got %b want 1", bus.m_axis_tvalid); end
    #2;
    rst = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    #1;
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_async_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_cmp++; if (hdr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_hv: got %b want 0", hdr_valid); end
    n_cmp++; if (hdr_src_mac !== 48'h0) begin n_fail++; $display("FAIL mid_async_src: got %h want 0", hdr_src_mac); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_ok = 0; exp_drop = 0; exp_runt = 0;
    @(negedge clk);
    rx_q.delete(); hv_cnt = 0;
    push_hdr(LOCAL_MAC, SRC_MAC, 16'h0800);
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
    send_q();
    wait_rx(3);
    exp_ok++;
    exp_q = '{9'h001, 9'h002, 9'h103};
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL mid_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_cmp++; if (hv_cnt !== 1) begin n_fail++; $display("FAIL mid_hv: got %0d want 1", hv_cnt); end
`ifdef ETH_RX_STATS_EN
    n_cmp++; if (stat_rx_ok !== 32'(exp_ok)) begin n_fail++; $display("FAIL mid_stat_ok: got %0d want %0d", stat_rx_ok, exp_ok); end
    n_cmp++; if (stat_rx_runt !== 32'(exp_runt)) begin n_fail++; $display("FAIL mid_stat_runt: got %0d want %0d", stat_rx_runt, exp_runt); end
`endif
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_mac_reject();
    test_bcast_type();
    test_runts();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (hv_long !== 0) begin n_fail++; $display("FAIL hv_width: got %0d wide pulses want 0", hv_long); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_hdr_parser.md
Name: eth_rx_hdr_parser

Overview:
- First receive stage of the Ethernet/IPv4/TCP datapath.
- Consumes raw byte-wide AXI-Stream frames from the MAC/bench driver and parses the 14-byte Ethernet header.
- Filters frames on destination MAC and EtherType; accepted frames have their header stripped and the IPv4 datagram forwarded downstream on AXI-Stream.
- Header fields are presented as a one-cycle sideband strobe for the IPv4 stage.

Parameters:
- DATA_WIDTH, 8, stream width in bits; only 8 is supported. Any other value is an elaboration error.
- PROMISC, 0, when 1 the destination-MAC filter is disabled.
- ACCEPT_BCAST, 1, when 1 a destination of FF:FF:FF:FF:FF:FF is accepted.

Ports:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- local_mac  in  48  station MAC; quasi-static, sampled at header byte 5.
- s_axis_tdata  in  8  frame byte; byte 0 = dst MAC MSB.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  last byte of frame.
- m_axis_tdata  out  8  IPv4 datagram byte.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last datagram byte.
- hdr_valid  out  1  one-cycle pulse: header accepted.
- hdr_dst_mac  out  48  destination MAC of last accepted frame.
- hdr_src_mac  out  48  source MAC of last accepted frame.
- hdr_ethertype  out  16  EtherType of last accepted frame (always 0x0800).

Behaviour:
- Reset: all outputs 0; state HDR; byte counter 0; skid buffer empty. Assertion is async and discards any in-flight frame. After deassertion, the next accepted byte is dst MAC byte 0.
- States:
  - HDR: s_axis_tready=1. Shift bytes into header registers, counter 0..13.
  - FWD: forward payload bytes through the skid buffer.
  - DROP: s_axis_tready=1; discard bytes until the tlast beat, then go to HDR.
- Header byte order: 0-5 dst, 6-11 src, 12-13 EtherType, big-endian.
- Accept condition, evaluated on the byte-13 beat: (PROMISC or dst==local_mac or (ACCEPT_BCAST and dst==all-ones)) and EtherType==0x0800 and tlast=0 on byte 13.
  - Pass: go to FWD. hdr_* registers update on the same edge; hdr_valid pulses high for exactly the following cycle.
  - Fail: go to DROP, or go straight to HDR if byte 13 carried tlast. No hdr_valid.
- Runt frames:
  - tlast on a header byte <13: frame dropped, return to HDR immediately, counter reset.
  - Header-only frame (14 bytes, tlast on byte 13): dropped, no hdr_valid.
- FWD:
  - s_axis_tready = skid buffer not full (registered).
  - Each accepted byte is written to the skid buffer with its tlast.
  - The tlast beat accepted on s_axis returns the state to HDR on the same edge.
  - Next frame's header bytes may be accepted while the buffer still drains.
- Latency: a payload byte accepted at edge N is visible on m_axis at N+1 (buffer empty case).
- m_axis: tvalid held until tready. tdata/tlast stable while tvalid=1 and tready=0. No byte lost, duplicated, or reordered under any backpressure pattern.
- hdr_* registers hold their value until the next accepted header.
- Simultaneous m_axis pop and s_axis push on a full-minus-one buffer is allowed: occupancy is unchanged.

Optional Feature:
- Macro ETH_RX_STATS_EN.
- Defined: adds outputs stat_rx_ok[31:0], stat_rx_drop_filter[31:0] and stat_rx_runt[31:0].
  - Counters are saturating and reset to 0.
  - ok increments on hdr_valid.
  - drop_filter increments on an address/EtherType reject.
  - runt increments on tlast before or at byte 13.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package eth_pkg:
  - ETH_HDR_BYTES=14, ETHERTYPE_IPV4=16'h0800, MAC_BCAST=48'hFFFF_FFFF_FFFF.
  - typedef eth_hdr_t: packed dst, src, ethertype.
  - typedef enum rx_state_t: HDR, FWD, DROP.
- Sub-module axis_skid_buf: 2-entry, DATA_WIDTH+1 bits (data plus tlast), registered ready. It is reused by later stages.

Test Plan:
- Accept, unicast: dst 02:00:00:00:00:02 (=local_mac), src 02:00:00:00:00:01, type 0800, payload 45 00 00 14 tlast → m_axis emits 45,00,00,14 with tlast on 14. One hdr_valid pulse with src=020000000001, ethertype=0800.
- MAC reject: same frame with dst 02:00:00:00:00:09, PROMISC=0 → zero m_axis beats, no hdr_valid, s_axis_tready=1 throughout. The next good frame is forwarded intact.
- Broadcast and EtherType: dst FF..FF with type 0800 → forwarded. dst local with type 86DD → dropped. Under ETH_RX_STATS_EN: ok=1, drop_filter=1.
- Runts: 10-byte frame with tlast, then a 14-byte header-only frame, then a good frame → only the good frame's payload appears. Under ETH_RX_STATS_EN: runt=2.
- Backpressure: 64-byte payload 00..3F with m_axis_tready random 30% high → output sequence exactly 00..3F with tlast only on 3F. tdata stable while stalled.
- Reset mid-payload: assert rst at payload byte 5 → m_axis_tvalid=0 and hdr_valid=0 asynchronously. After release, a fresh good frame is forwarded correctly.
